// File: rtl/nios_hps_system_nios_leds_gpio_out.sv
// Avalon-MM LED output PIO with DATA/OUTSET/OUTCLEAR registers.
// Define LEDS_GPIO_BLINK_EN to build the BLINK mask, prescaler and STATUS.
module nios_hps_system_nios_leds_gpio_out #(
  parameter int          WIDTH       = 4,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          PRESCALE    = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic             read,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] RST = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] mask_d;
  logic [31:0]      rd_d;
  logic             wr_data;
  logic             wr_set;
  logic             wr_clr;
  logic             unused;

  assign wd      = writedata[WIDTH-1:0];
  assign wr_data = write & (address == 3'd0);
  assign wr_set  = write & (address == 3'd2);
  assign wr_clr  = write & (address == 3'd3);
  assign unused  = ^{read, writedata};

  always_comb begin
    data_d = data_q;
    unique case (1'b1)
      wr_data: data_d = wd;
      wr_set:  data_d = data_q | wd;
      wr_clr:  data_d = data_q & ~wd;
      default: ;
    endcase
  end

`ifdef LEDS_GPIO_BLINK_EN
  localparam int             CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

  logic [WIDTH-1:0] blink_q;
  logic [WIDTH-1:0] blink_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             phase_q;
  logic             phase_d;
  logic             wr_blink;

  assign wr_blink = write & (address == 3'd1);

  // A BLINK write restarts the half-period, even over a wrap
  always_comb begin
    blink_d = blink_q;
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (wr_blink) begin
      blink_d = wd;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      blink_q <= blink_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign mask_d = ~blink_d | {WIDTH{phase_d}};

  always_comb begin
    rd_d = '0;
    unique case (address)
      3'd0:    rd_d = 32'(data_d);
      3'd1:    rd_d = 32'(blink_d);
      3'd4:    rd_d = {31'b0, phase_d};
      default: rd_d = '0;
    endcase
  end
`else
  assign mask_d = '1;

  always_comb begin
    rd_d = '0;
    if (address == 3'd0) rd_d = 32'(data_d);
  end
`endif

  // Outputs load next-state values so writes show at the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RST;
      readdata <= '0;
      out_port <= RST;
    end else begin
      data_q   <= data_d;
      readdata <= rd_d;
      out_port <= data_d & mask_d;
    end
  end

endmodule
